dsp38_mac_sequencer: RTL and testbench
======================================

DSP38_MAC_SEQUENCER -- requirements
Module: dsp38_mac_sequencer

Interface
REQ-001 SHALL have parameter DSP_LATENCY, default 2: cycles from a pair driven on DSP_A/DSP_B until DSP_Z reflects it (legal 1..3).
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum pairs per job (CFG_LEN width = 7).
REQ-003 CLK  in  1  single clock, all logic rising-edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 CFG_VALID / CFG_READY  in / out  1 / 1  job-configuration handshake.
REQ-006 CFG_LEN  in  7  number of A/B pairs in the job (0..MAX_LEN).
REQ-007 CFG_SHIFT  in  6  right-shift for DSP_SHIFT_RIGHT; CFG_ROUND, CFG_SATURATE, CFG_SUBTRACT  in  1 each.
REQ-008 IN_VALID / IN_READY  in / out  1 / 1  operand stream handshake; IN_A  in  20; IN_B  in  18.
REQ-009 OUT_VALID / OUT_READY  out / in  1 / 1  result handshake; OUT_Z  out  38.
REQ-010 DSP_A  out 20; DSP_B  out 18; DSP_LOAD_ACC  out 1; DSP_FEEDBACK  out 3; DSP_SHIFT_RIGHT  out 6; DSP_ROUND, DSP_SATURATE, DSP_SUBTRACT  out 1 each: to DSP38 (MULTIPLY_ACCUMULATE mode).
REQ-011 DSP_Z  in  38  accumulator output from DSP38.
REQ-012 BUSY  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: CFG_READY=1; on CFG_VALID&CFG_READY latch CFG_*; go RUN if CFG_LEN>0, else DONE with OUT_Z=0.
REQ-015 RUN: IN_READY=1; each IN_VALID&IN_READY cycle drives IN_A/IN_B onto DSP_A/DSP_B combinationally and increments pair count.
REQ-016 First accepted pair of a job SHALL assert DSP_LOAD_ACC=1 in the same cycle; all later pairs DSP_LOAD_ACC=0.
REQ-017 RUN cycles with IN_VALID=0 (bubbles) SHALL drive DSP_A=0, DSP_B=0, DSP_LOAD_ACC=0 (accumulate zero); bubbles before the first pair SHALL also drive DSP_LOAD_ACC=0.
REQ-018 After accepting pair number CFG_LEN, SHALL leave RUN next cycle (IN_READY=0) and enter DRAIN.
REQ-019 DRAIN SHALL last exactly DSP_LATENCY cycles driving zeros; at the final DRAIN edge capture DSP_Z into OUT_Z and enter DONE.
REQ-020 Latency: last pair accepted in cycle m -> OUT_VALID=1 in cycle m+DSP_LATENCY+1.
REQ-021 DONE: OUT_VALID=1, OUT_Z stable until OUT_VALID&OUT_READY; then IDLE next cycle; no new CFG accepted in DONE.
REQ-022 DSP_SHIFT_RIGHT, DSP_ROUND, DSP_SATURATE, DSP_SUBTRACT SHALL equal latched config from RUN entry through DONE; 0 in IDLE.
REQ-023 DSP_FEEDBACK SHALL be constant 3'b000.
REQ-024 CFG_READY, IN_READY and OUT_VALID SHALL never be high simultaneously; IN_READY SHALL be 0 outside RUN.
REQ-025 CFG_LEN > MAX_LEN SHALL be clamped to MAX_LEN.

Reset
REQ-026 RESET=1 at any edge SHALL force IDLE next cycle, abandoning any job; pair count cleared.
REQ-027 During and after reset: CFG_READY=0 while RESET=1, then 1; IN_READY=0, OUT_VALID=0, OUT_Z=0, BUSY=0, DSP_A=0, DSP_B=0, DSP_LOAD_ACC=0, all DSP config outputs 0.

Verification
REQ-028 LEN=4, pairs (1,1),(2,2),(3,3),(4,4) back-to-back, DSP model latency 2 -> DSP_LOAD_ACC only on pair 1, OUT_VALID 3 cycles after pair 4, OUT_Z=30.
REQ-029 LEN=3, pairs (5,2),(−1,7),(3,3) with 2 bubble cycles between pairs 1 and 2 -> OUT_Z=12, DSP_A/B=0 on bubbles, pair count unaffected.
REQ-030 LEN=0 -> DONE next cycle, OUT_Z=0, IN_READY never asserted.
REQ-031 Result held with OUT_READY=0 for 5 cycles -> OUT_Z stable, CFG_READY=0 and IN_READY=0 throughout; IDLE one cycle after OUT_READY=1.
REQ-032 RESET pulsed after pair 2 of LEN=8 -> IDLE next cycle, all outputs at reset values; next LEN=1 job (6,7) yields OUT_Z=42 with LOAD_ACC on its pair.
REQ-033 CFG_LEN=100 with MAX_LEN=64 -> exactly 64 pairs accepted, IN_READY drops after pair 64.

Source files
------------

// File: rtl/dsp38_mac_sequencer.sv
// Job sequencer for a DSP38 in multiply-accumulate mode: it accepts a job config,
// streams LEN operand pairs into the DSP, waits for the pipeline and returns the accumulator.
module dsp38_mac_sequencer #(
  parameter int DSP_LATENCY = 2,
  parameter int MAX_LEN     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_len,
  input  logic [5:0]  cfg_shift,
  input  logic        cfg_round,
  input  logic        cfg_saturate,
  input  logic        cfg_subtract,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_a,
  input  logic [17:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [37:0] out_z,
  output logic [19:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic        dsp_load_acc,
  output logic [2:0]  dsp_feedback,
  output logic [5:0]  dsp_shift_right,
  output logic        dsp_round,
  output logic        dsp_saturate,
  output logic        dsp_subtract,
  input  logic [37:0] dsp_z,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [6:0] MAX_LEN_V  = 7'(MAX_LEN);
  localparam logic [1:0] LAST_DRAIN = 2'(DSP_LATENCY - 1);

  state_t      state;
  logic [6:0]  len;
  logic [6:0]  count;
  logic [1:0]  drain_cnt;
  logic        cfg_ready_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [6:0]  len_clamped;
  logic        accept;

  // Handshake flags are registered; the reset gate keeps them low during the reset cycle itself.
  assign cfg_ready    = cfg_ready_r & ~reset;
  assign in_ready     = in_ready_r & ~reset;
  assign out_valid    = out_valid_r & ~reset;
  assign busy         = busy_r & ~reset;
  assign dsp_feedback = 3'b000;

  assign len_clamped  = (cfg_len > MAX_LEN_V) ? MAX_LEN_V : cfg_len;
  assign accept       = in_valid & in_ready;

  // Operands pass straight through on accepted beats; bubbles accumulate zero.
  assign dsp_a        = accept ? in_a : 20'd0;
  assign dsp_b        = accept ? in_b : 18'd0;
  assign dsp_load_acc = accept & (count == 7'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      len             <= 7'd0;
      count           <= 7'd0;
      drain_cnt       <= 2'd0;
      cfg_ready_r     <= 1'b1;
      in_ready_r      <= 1'b0;
      out_valid_r     <= 1'b0;
      busy_r          <= 1'b0;
      out_z           <= 38'd0;
      dsp_shift_right <= 6'd0;
      dsp_round       <= 1'b0;
      dsp_saturate    <= 1'b0;
      dsp_subtract    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            len             <= len_clamped;
            count           <= 7'd0;
            cfg_ready_r     <= 1'b0;
            busy_r          <= 1'b1;
            dsp_shift_right <= cfg_shift;
            dsp_round       <= cfg_round;
            dsp_saturate    <= cfg_saturate;
            dsp_subtract    <= cfg_subtract;
            if (len_clamped != 7'd0) begin
              state      <= RUN;
              in_ready_r <= 1'b1;
            end else begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              out_z       <= 38'd0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + 7'd1;
            if (count + 7'd1 == len) begin
              state      <= DRAIN;
              in_ready_r <= 1'b0;
              drain_cnt  <= 2'd0;
            end
          end
        end
        DRAIN: begin
          // The last pair reaches DSP_Z exactly on the final drain cycle.
          if (drain_cnt == LAST_DRAIN) begin
            out_z       <= dsp_z;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state           <= IDLE;
            out_valid_r     <= 1'b0;
            cfg_ready_r     <= 1'b1;
            busy_r          <= 1'b0;
            count           <= 7'd0;
            dsp_shift_right <= 6'd0;
            dsp_round       <= 1'b0;
            dsp_saturate    <= 1'b0;
            dsp_subtract    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Self-checking bench: table-driven jobs, hand-written corner sequences and random jobs,
// with a latency-accurate DSP38 accumulator model and a sum-of-products reference.
module tb_dsp38_mac_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid, cfg_ready;
  logic [6:0]  cfg_len;
  logic [5:0]  cfg_shift;
  logic        cfg_round, cfg_saturate, cfg_subtract;
  logic        in_valid, in_ready;
  logic [19:0] in_a;
  logic [17:0] in_b;
  logic        out_valid, out_ready;
  logic [37:0] out_z;
  logic [19:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_load_acc;
  logic [2:0]  dsp_feedback;
  logic [5:0]  dsp_shift_right;
  logic        dsp_round, dsp_saturate, dsp_subtract;
  logic [37:0] dsp_z;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  int job_a [0:127];
  int job_b [0:127];
  int job_gap [0:127];

  dsp38_mac_sequencer #(.DSP_LATENCY(LAT), .MAX_LEN(64)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .cfg_round(cfg_round), .cfg_saturate(cfg_saturate), .cfg_subtract(cfg_subtract),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc), .dsp_feedback(dsp_feedback),
    .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round), .dsp_saturate(dsp_saturate),
    .dsp_subtract(dsp_subtract), .dsp_z(dsp_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // DSP38 MAC model: accumulator register plus extra stages so DSP_Z lags the operands by LAT cycles.
  logic signed [37:0] acc_pipe [0:3];
  logic signed [37:0] prod;
  assign prod  = $signed(dsp_a) * $signed(dsp_b);
  assign dsp_z = acc_pipe[LAT-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc_pipe[i] <= 38'sd0;
    end else begin
      if (dsp_load_acc) acc_pipe[0] <= dsp_subtract ? -prod : prod;
      else              acc_pipe[0] <= dsp_subtract ? acc_pipe[0] - prod : acc_pipe[0] + prod;
      for (int i = 1; i < 4; i++) acc_pipe[i] <= acc_pipe[i-1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready/valid exclusivity and the constant feedback select hold every cycle.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      chk("handshake_exclusive",
          {63'd0, (cfg_ready & in_ready) | (cfg_ready & out_valid) | (in_ready & out_valid)}, 64'd0);
      chk("dsp_feedback", {61'd0, dsp_feedback}, 64'd0);
    end
  end

  function automatic logic [37:0] ref_sum(input int n, input logic sub);
    longint s;
    s = 0;
    for (int k = 0; k < n; k++) s += longint'(job_a[k]) * longint'(job_b[k]);
    if (sub) s = -s;
    return 38'(s);
  endfunction

  task automatic run_job(input int len_cfg, input int npairs, input logic sub, input logic [5:0] shift,
                         input logic rnd, input logic sat, input int hold, input logic [37:0] exp_z);
    int lat;
    int exp_lat;
    logic [37:0] z_seen;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 7'(len_cfg); cfg_shift = shift;
    cfg_round = rnd; cfg_saturate = sat; cfg_subtract = sub;
    #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    chk("busy_idle", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    chk("dsp_shift_idle", dsp_shift_right, 0);
    for (int k = 0; k < npairs; k++) begin
      for (int g = 0; g < job_gap[k]; g++) begin
        @(negedge clk);
        cfg_valid = 1'b0; in_valid = 1'b0;
        in_a = 20'($urandom); in_b = 18'($urandom);
        #1;
        chk("in_ready_bubble", in_ready, 1);
        chk("dsp_a_bubble", dsp_a, 0);
        chk("dsp_b_bubble", dsp_b, 0);
        chk("load_acc_bubble", dsp_load_acc, 0);
      end
      @(negedge clk);
      cfg_valid = 1'b0; in_valid = 1'b1;
      in_a = 20'(job_a[k]); in_b = 18'(job_b[k]);
      #1;
      chk("in_ready_run", in_ready, 1);
      chk("dsp_a_pass", dsp_a, in_a);
      chk("dsp_b_pass", dsp_b, in_b);
      chk("load_acc_pair", dsp_load_acc, (k == 0));
      chk("dsp_shift_run", dsp_shift_right, shift);
      chk("dsp_flags_run", {dsp_round, dsp_saturate, dsp_subtract}, {rnd, sat, sub});
      chk("busy_run", busy, 1);
    end
    // One more offered beat after the job: it must be refused.
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b1; in_a = 20'd77; in_b = 18'd5;
    lat = 1;
    #1;
    chk("in_ready_after_last", in_ready, 0);
    chk("dsp_a_after_last", dsp_a, 0);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_drain", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    exp_lat = (npairs == 0) ? 1 : LAT + 1;
    chk("result_latency", lat, exp_lat);
    chk("out_z", out_z, exp_z);
    chk("busy_done", busy, 1);
    chk("dsp_subtract_done", dsp_subtract, sub);
    z_seen = out_z;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_z", out_z, z_seen);
      chk("hold_cfg_ready", cfg_ready, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_cfg_outs", {dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract}, 0);
  endtask

  typedef struct packed {
    logic [6:0]       len;
    logic [3:0][19:0] a;
    logic [3:0][17:0] b;
    logic [3:0][1:0]  gap;
    logic             sub;
    logic [5:0]       shift;
    logic [3:0]       hold;
    logic [37:0]      exp_z;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    // Element 0 of each packed list is the first pair.
    vecs[0] = '{7'd4, {20'd4, 20'd3, 20'd2, 20'd1}, {18'd4, 18'd3, 18'd2, 18'd1},
                8'h00, 1'b0, 6'd0, 4'd0, 38'd30};
    vecs[1] = '{7'd3, {20'd0, 20'd3, 20'hFFFFF, 20'd5}, {18'd0, 18'd3, 18'd7, 18'd2},
                8'h08, 1'b0, 6'd3, 4'd5, 38'd12};
    vecs[2] = '{7'd2, {20'd0, 20'd0, 20'hFFFFE, 20'd3}, {18'd0, 18'd0, 18'd5, 18'd4},
                8'h00, 1'b1, 6'd12, 4'd1, 38'h3FFFFFFFFE};
    vecs[3] = '{7'd0, 80'd0, 72'd0, 8'h00, 1'b0, 6'd7, 4'd2, 38'd0};

    reset = 1'b1; cfg_valid = 1'b0; cfg_len = 7'd0; cfg_shift = 6'd0;
    cfg_round = 1'b0; cfg_saturate = 1'b0; cfg_subtract = 1'b0;
    in_valid = 1'b0; in_a = 20'd0; in_b = 18'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("post_reset_cfg_ready", cfg_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_out_z", out_z, 0);
    chk("post_reset_dsp", {dsp_a, dsp_b, dsp_load_acc}, 0);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        job_a[k]   = int'($signed(vecs[i].a[k]));
        job_b[k]   = int'($signed(vecs[i].b[k]));
        job_gap[k] = int'(vecs[i].gap[k]);
      end
      run_job(int'(vecs[i].len), int'(vecs[i].len), vecs[i].sub, vecs[i].shift,
              vecs[i].sub, vecs[i].sub, int'(vecs[i].hold), vecs[i].exp_z);
    end

    // Reset in the middle of an 8-pair job, then a fresh single-pair job.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 7'd8; cfg_shift = 6'd9; cfg_subtract = 1'b1; cfg_round = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0; in_valid = 1'b1; in_a = 20'(k + 2); in_b = 18'(k + 3);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_a = 20'd9; in_b = 18'd9;
    #1;
    chk("midjob_reset_cfg_ready", cfg_ready, 0);
    chk("midjob_reset_in_ready", in_ready, 0);
    chk("midjob_reset_dsp_a", dsp_a, 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("after_reset_cfg_ready", cfg_ready, 1);
    chk("after_reset_busy", busy, 0);
    chk("after_reset_out_valid", out_valid, 0);
    chk("after_reset_out_z", out_z, 0);
    chk("after_reset_cfg_outs", {dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract}, 0);
    chk("after_reset_load_acc", dsp_load_acc, 0);
    job_a[0] = 6; job_b[0] = 7; job_gap[0] = 0;
    run_job(1, 1, 1'b0, 6'd0, 1'b0, 1'b0, 0, 38'd42);

    // Oversized length is clamped to 64 pairs.
    for (int k = 0; k < 64; k++) begin
      job_a[k] = int'($urandom_range(400)) - 200;
      job_b[k] = int'($urandom_range(400)) - 200;
      job_gap[k] = 0;
    end
    run_job(100, 64, 1'b0, 6'd1, 1'b0, 1'b1, 0, ref_sum(64, 1'b0));

    // Random jobs against the sum-of-products reference.
    for (int j = 0; j < 6; j++) begin
      int n;
      logic sub;
      n = int'($urandom_range(12, 1));
      sub = 1'($urandom);
      for (int k = 0; k < n; k++) begin
        job_a[k]   = int'($urandom_range(2000)) - 1000;
        job_b[k]   = int'($urandom_range(2000)) - 1000;
        job_gap[k] = int'($urandom_range(2));
      end
      run_job(n, n, sub, 6'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(3)), ref_sum(n, sub));
    end

    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
